sequential_carry_resolver: RTL
==============================

// Module: sequential_carry_resolver
//
// PURPOSE
// Parametrised, pipelined successor to the combinational unsigned carry correction. Resolves a
// redundant multi-symbol number (symbols wider than LOGRADIX bits) into canonical radix-2^LOGRADIX digits.
// Ripples carries LSB-first, SYMBOLSPERCYCLE symbols per clock. Supports signed or unsigned symbols.
// Sits between the multiplier/accumulator array and convertfrommultisymbols in the modular squaring datapath.
//
// PARAMETERS
// NUMSYMBOLS          8   symbols per operand; must be a multiple of SYMBOLSPERCYCLE
// INPUTSYMBOLBITWIDTH 6   bits per input symbol (> LOGRADIX)
// LOGRADIX            4   canonical digit width
// SYMBOLSPERCYCLE     2   symbols resolved per RESOLVE cycle
// SYMBOLS_ARE_SIGNED  0   1: input symbols and carries are two's complement
//
// PORTS
// clk         in   1                              clock
// rst_n       in   1                              asynchronous, active-low reset
// in_valid    in   1                              operand present on data_in
// in_ready    out  1                              block accepts operand this cycle
// data_in     in   [INPUTSYMBOLBITWIDTH-1:0] x NUMSYMBOLS   redundant symbols, index 0 = LS
// out_valid   out  1                              data_out/carry_out valid
// out_ready   in   1                              consumer takes result this cycle
// data_out    out  [LOGRADIX:0] x NUMSYMBOLS     canonical digits, bit LOGRADIX always 0
// carry_out   out  [CARRYWIDTH-1:0]               final carry past MS symbol (signed if SYMBOLS_ARE_SIGNED)
//
// BEHAVIOUR
// - Reset (rst_n low, async): state IDLE; in_ready=0 while asserted, out_valid=0, data_out=0, carry_out=0.
// - CARRYWIDTH = INPUTSYMBOLBITWIDTH-LOGRADIX+1; NUMSTEPS = NUMSYMBOLS/SYMBOLSPERCYCLE.
// - Per symbol i: t = sym_i + c (sign-extended if signed, zero-extended otherwise);
//   digit_i = t[LOGRADIX-1:0]; c_next = t >>> LOGRADIX (arithmetic if signed, logical if unsigned).
//   c starts at 0 for each operand. No truncation of t.
// - States: IDLE -> RESOLVE on in_valid&&in_ready (operand captured into internal register, step counter=0).
//   RESOLVE: each cycle resolves symbols [step*SPC .. step*SPC+SPC-1], stores digits, updates carry reg;
//   after step NUMSTEPS-1 -> DONE.
//   DONE: out_valid=1, data_out/carry_out held stable. out_ready -> IDLE, or -> RESOLVE directly if
//   in_valid in the same cycle (back-to-back).
// - in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational from out_ready only.
// - Latency: out_valid rises NUMSTEPS cycles after accepting edge.
//   Throughput: one operand per NUMSTEPS+1 cycles under continuous ready.
// - Backpressure: DONE holds indefinitely; outputs must not change while out_valid && !out_ready.
// - data_in is sampled only at the accepting edge; later changes are ignored.
// - Reset mid-RESOLVE or mid-DONE: result discarded; no out_valid after reset release until a new accept.
// - NUMSTEPS==1 is legal: RESOLVE lasts one cycle.
//
// STRUCTURE
// - carrycorrection_pkg: function carry_width(ibw,lr), function num_steps(ns,spc), state enum
//   {IDLE,RESOLVE,DONE}.
// - Sub-module carry_resolve_slice: combinational ripple over SYMBOLSPERCYCLE symbols.
//   Ports: carry_in, symbols_in; outputs: digits_out, carry_out.
//   Same parameters plus SYMBOLS_ARE_SIGNED.
// - Top: FSM, step counter ($clog2(NUMSTEPS) bits, min 1), operand register, digit register, carry register.
//   Slice input muxed by step.
//
// TESTING (defaults NS=4, IBW=6, LR=4, SPC=2, unsigned unless stated)
// 1. data_in={0x3F,0x3F,0x3F,0x3F}, out_ready=1 -> after 2 cycles:
//    digits[0..3]={F,2,3,3}, carry_out=4; value 275247 preserved.
// 2. SIGNED=1, data_in={0x3F(-1),0,0,0} -> digits {F,F,F,F}, carry_out=-1 (all ones).
// 3. Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0.
//    Then release with in_valid=1 -> accepted same cycle, next result after 2 cycles.
// 4. Reset mid-RESOLVE (rst_n low 1 cycle after accept) -> out_valid=0, data_out=0, carry_out=0.
//    No spurious result; the next operand resolves correctly.
// 5. Random: randgen operand split into 4-bit digits, each shifted left 1 (symbols 0x00..0x1E) -> data_out
//    reassembled via convertfrommultisymbols equals input<<1; carry_out = MS-digit overflow; 10k operands.
// 6. Sweep SPC=1,NS=8 and SPC=4,NS=4 -> latency 8 and 1 cycles resp.; results match the reference model.

Source files
------------

// File: rtl/carrycorrection_pkg.sv
// Shared definitions for the sequential carry resolver.
//   carry_width : width of the inter-symbol carry for a given symbol/digit width
//   num_steps   : number of RESOLVE cycles per operand
//   step_width  : step counter width (never below 1 bit)
//   state_t     : resolver FSM states
package carrycorrection_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int carry_width(input int ibw, input int lr);
    return ibw - lr + 1;
  endfunction

  function automatic int num_steps(input int ns, input int spc);
    return ns / spc;
  endfunction

  function automatic int step_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/carry_resolve_slice.sv
// Combinational carry ripple over SYMBOLSPERCYCLE redundant symbols, LS first.
// Ports:
//   carry_in   [CARRYWIDTH-1:0]                           incoming carry (signed if SYMBOLS_ARE_SIGNED)
//   symbols_in [SYMBOLSPERCYCLE-1:0][INPUTSYMBOLBITWIDTH-1:0]  redundant symbols, index 0 = LS
//   digits_out [SYMBOLSPERCYCLE-1:0][LOGRADIX-1:0]         canonical digits
//   carry_out  [CARRYWIDTH-1:0]                           carry past the MS symbol of the slice
module carry_resolve_slice
  import carrycorrection_pkg::*;
#(
  parameter int SYMBOLSPERCYCLE     = 2,
  parameter int INPUTSYMBOLBITWIDTH = 6,
  parameter int LOGRADIX            = 4,
  parameter int SYMBOLS_ARE_SIGNED  = 0,
  localparam int CARRYWIDTH         = carry_width(INPUTSYMBOLBITWIDTH, LOGRADIX)
) (
  input  logic [CARRYWIDTH-1:0]                                  carry_in,
  input  logic [SYMBOLSPERCYCLE-1:0][INPUTSYMBOLBITWIDTH-1:0]    symbols_in,
  output logic [SYMBOLSPERCYCLE-1:0][LOGRADIX-1:0]               digits_out,
  output logic [CARRYWIDTH-1:0]                                  carry_out
);

  // Two guard bits above the symbol width hold any symbol+carry sum exactly,
  // so the running sum is never truncated.
  localparam int TW = INPUTSYMBOLBITWIDTH + 2;

  logic [TW-1:0] w_c;
  logic [TW-1:0] w_t;

  always_comb begin
    digits_out = '0;
    w_t        = '0;
    if (SYMBOLS_ARE_SIGNED != 0) begin
      w_c = {{(TW-CARRYWIDTH){carry_in[CARRYWIDTH-1]}}, carry_in};
    end else begin
      w_c = {{(TW-CARRYWIDTH){1'b0}}, carry_in};
    end
    for (int i = 0; i < SYMBOLSPERCYCLE; i++) begin
      if (SYMBOLS_ARE_SIGNED != 0) begin
        w_t = {{(TW-INPUTSYMBOLBITWIDTH){symbols_in[i][INPUTSYMBOLBITWIDTH-1]}}, symbols_in[i]} + w_c;
        w_c = $signed(w_t) >>> LOGRADIX;
      end else begin
        w_t = {{(TW-INPUTSYMBOLBITWIDTH){1'b0}}, symbols_in[i]} + w_c;
        w_c = w_t >> LOGRADIX;
      end
      digits_out[i] = w_t[LOGRADIX-1:0];
    end
    // The carry magnitude is bounded by the symbol width, so the top guard
    // bits are pure sign/zero extension and can be dropped.
    carry_out = w_c[CARRYWIDTH-1:0];
  end

endmodule

// File: rtl/sequential_carry_resolver.sv
// Pipelined carry resolver: converts a redundant multi-symbol operand into
// canonical radix-2^LOGRADIX digits, SYMBOLSPERCYCLE symbols per clock.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake (data_in sampled at the accepting edge)
//   data_in                 [NUMSYMBOLS-1:0][INPUTSYMBOLBITWIDTH-1:0], index 0 = LS
//   out_valid / out_ready   result handshake
//   data_out                [NUMSYMBOLS-1:0][LOGRADIX:0], bit LOGRADIX always 0
//   carry_out               [CARRYWIDTH-1:0] carry past the MS symbol
module sequential_carry_resolver
  import carrycorrection_pkg::*;
#(
  parameter int NUMSYMBOLS          = 8,
  parameter int INPUTSYMBOLBITWIDTH = 6,
  parameter int LOGRADIX            = 4,
  parameter int SYMBOLSPERCYCLE     = 2,
  parameter int SYMBOLS_ARE_SIGNED  = 0,
  localparam int CARRYWIDTH         = carry_width(INPUTSYMBOLBITWIDTH, LOGRADIX),
  localparam int NUMSTEPS           = num_steps(NUMSYMBOLS, SYMBOLSPERCYCLE),
  localparam int STEPW              = step_width(NUMSTEPS)
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [NUMSYMBOLS-1:0][INPUTSYMBOLBITWIDTH-1:0]    data_in,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [NUMSYMBOLS-1:0][LOGRADIX:0]                 data_out,
  output logic [CARRYWIDTH-1:0]                             carry_out
);

  localparam logic [STEPW-1:0] LAST_STEP = STEPW'(NUMSTEPS - 1);

  state_t                                                 r_state;
  logic [STEPW-1:0]                                       r_step;
  logic [NUMSYMBOLS-1:0][INPUTSYMBOLBITWIDTH-1:0]         r_operand;
  logic [NUMSYMBOLS-1:0][LOGRADIX-1:0]                    r_digits;
  logic [CARRYWIDTH-1:0]                                  r_carry;
  logic                                                   r_out_valid;

  logic [SYMBOLSPERCYCLE-1:0][INPUTSYMBOLBITWIDTH-1:0]    w_slice_syms;
  logic [SYMBOLSPERCYCLE-1:0][LOGRADIX-1:0]               w_slice_digits;
  logic [CARRYWIDTH-1:0]                                  w_slice_carry;
  logic                                                   w_accept;

  // Gating with rst_n keeps in_ready low for the whole reset assertion,
  // even though the state register already reads IDLE.
  assign in_ready  = rst_n && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign carry_out = r_carry;

  always_comb begin
    for (int i = 0; i < NUMSYMBOLS; i++) begin
      data_out[i] = {1'b0, r_digits[i]};
    end
  end

  always_comb begin
    w_slice_syms = r_operand[SYMBOLSPERCYCLE-1:0];
    for (int s = 0; s < NUMSTEPS; s++) begin
      if (r_step == STEPW'(s)) begin
        w_slice_syms = r_operand[s*SYMBOLSPERCYCLE +: SYMBOLSPERCYCLE];
      end
    end
  end

  carry_resolve_slice #(
    .SYMBOLSPERCYCLE     (SYMBOLSPERCYCLE),
    .INPUTSYMBOLBITWIDTH (INPUTSYMBOLBITWIDTH),
    .LOGRADIX            (LOGRADIX),
    .SYMBOLS_ARE_SIGNED  (SYMBOLS_ARE_SIGNED)
  ) u_slice (
    .carry_in   (r_carry),
    .symbols_in (w_slice_syms),
    .digits_out (w_slice_digits),
    .carry_out  (w_slice_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_operand   <= '0;
      r_digits    <= '0;
      r_carry     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_operand <= data_in;
            r_step    <= '0;
            r_carry   <= '0;
            r_state   <= RESOLVE;
          end
        end
        RESOLVE: begin
          for (int s = 0; s < NUMSTEPS; s++) begin
            if (r_step == STEPW'(s)) begin
              r_digits[s*SYMBOLSPERCYCLE +: SYMBOLSPERCYCLE] <= w_slice_digits;
            end
          end
          r_carry <= w_slice_carry;
          if (r_step == LAST_STEP) begin
            r_step      <= '0;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            // Back-to-back: the next operand is taken in the same cycle the
            // result is consumed.
            if (w_accept) begin
              r_operand <= data_in;
              r_step    <= '0;
              r_carry   <= '0;
              r_state   <= RESOLVE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
